// File: rtl/mult_pkg.sv
// mult_pkg: definitions shared across the multiplier family.
//   - state_t : two-state sequencer encoding (ST_IDLE=1'b0, ST_RUN=1'b1)
//   - DEFAULT_WIDTH : default operand width (32) used by the multipliers
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/busy/done handshake and operand/result bus
// of the sequential multiplier.
//   start   : request, honoured only while busy=0
//   a, b    : multiplicand / multiplier (WIDTH bits), captured on acceptance
//   busy    : operation in progress
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result, held until the next acceptance
// Modports: master = requester (drives start/a/b), slave = multiplier.
interface shift_add_multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/ripple_adder.sv
// ripple_adder: combinational N-bit adder built as a chain of full-adder
// cells.
//   a_i, b_i : N-bit addends
//   sum_o    : N-bit sum
//   cout_o   : carry out of the top bit
// full_adder_cell: one-bit full adder (a_i, b_i, c_i -> s_o, c_o).

module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    logic [N:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        full_adder_cell u_fa (
            .a_i (a_i[gi]),
            .b_i (b_i[gi]),
            .c_i (carry[gi]),
            .s_o (sum_o[gi]),
            .c_o (carry[gi+1])
        );
    end

    assign cout_o = carry[N];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH -> 2*WIDTH
// multiplier, one shift-and-add step per clock.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : shift_add_multiplier_if.slave (start, a, b in; busy, done, product out)
// Latency is WIDTH cycles from acceptance to the done pulse. The product is
// held from done until the next accepted start.
// Build option: define EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero (latency max(msb_index(b)+1, 1)).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_add_multiplier_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t            state_q,   state_d;
    logic [PW-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]  mplier_q,  mplier_d;
    logic [PW-1:0]     product_q, product_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic              done_q,    done_d;

    logic [PW-1:0]     sum;
    logic              adder_cout_unused;
    logic              last_step;

    // Operands are zero-extended, so the running sum can never exceed
    // 2*WIDTH bits; the adder's carry-out is not needed.
    ripple_adder #(.N(PW)) u_adder (
        .a_i    (product_q),
        .b_i    (mcand_q),
        .sum_o  (sum),
        .cout_o (adder_cout_unused)
    );

`ifdef EARLY_TERM_EN
    // Stop once the bits still to be shifted in are all zero: no further
    // partial product can contribute.
    assign last_step = (counter_q == LAST_CNT) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_step = (counter_q == LAST_CNT);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        counter_d = counter_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_RUN;
                    mcand_d   = {{WIDTH{1'b0}}, bus.a};
                    mplier_d  = bus.b;
                    product_d = '0;
                    counter_d = '0;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    product_d = sum;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                counter_d = counter_q + CNT_W'(1);
                if (last_step) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            counter_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            counter_q <= counter_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of the shift-and-add multiplier at
// WIDTH=8 plus a random sweep of a WIDTH=32 instance against a*b.
// Expected latencies follow the EARLY_TERM_EN build option when it is defined.
module tb_shift_add_multiplier;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    int   cyc;

    shift_add_multiplier_if #(.WIDTH(8))  bus8  ();
    shift_add_multiplier_if #(.WIDTH(32)) bus32 ();

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    shift_add_multiplier #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Latency of an 8-bit operation with multiplier b.
    function automatic int lat8(input logic [7:0] b);
`ifdef EARLY_TERM_EN
        int m;
        m = 1;
        for (int i = 0; i < 8; i++) if (b[i]) m = i + 1;
        return m;
`else
        return 8 + 0 * int'(b[0]);
`endif
    endfunction

    function automatic int lat32(input logic [31:0] b);
`ifdef EARLY_TERM_EN
        int m;
        m = 1;
        for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
        return m;
`else
        return 32 + 0 * int'(b[0]);
`endif
    endfunction

    // Issue start for one edge on the 8-bit DUT; returns the cycle stamp of E0.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, output int t0);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        tick();
        bus8.start = 1'b0;
        t0 = cyc;
    endtask

    // Wait (bounded) for done on the 8-bit DUT; returns cycles since t0.
    task automatic wait_done8(input string tag, input int t0, output int lat);
        while (!bus8.done && (cyc - t0) < 40) tick();
        lat = cyc - t0;
        if (!bus8.done) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p);
        int t0;
        int lat;
        accept8(a, b, t0);
        chk({tag, "_busy"}, 64'(bus8.busy), 64'd1);
        wait_done8(tag, t0, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(lat8(b)));
        chk({tag, "_prod"}, 64'(bus8.product), 64'(exp_p));
        chk({tag, "_busy_at_done"}, 64'(bus8.busy), 64'd0);
        $display("op %s: %0d * %0d -> %0d in %0d cycles", tag, a, b, bus8.product, lat);
    endtask

    initial begin
        int t0;
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rexp;
        int bad_done;

        n_cmp = 0;
        n_mis = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus32.start = 1'b0;
        bus32.a     = '0;
        bus32.b     = '0;

        // 1. reset for two cycles, then idle
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(bus8.busy), 64'd0);
        chk("rst_done", 64'(bus8.done), 64'd0);
        chk("rst_prod", 64'(bus8.product), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("idle_busy", 64'(bus8.busy), 64'd0);
        chk("idle_prod", 64'(bus8.product), 64'd0);

        // 2. 200*150, single-cycle done, result held
        run8("t200x150", 8'd200, 8'd150, 16'd30000);
        tick();
        chk("t200x150_done_pulse", 64'(bus8.done), 64'd0);
        bus8.a = 8'd9;
        bus8.b = 8'd9;
        for (int i = 0; i < 3; i++) tick();
        chk("t200x150_hold", 64'(bus8.product), 64'd30000);

        // 3. boundaries
        run8("t255x255", 8'd255, 8'd255, 16'd65025);
        tick();
        run8("t0x77", 8'd0, 8'd77, 16'd0);
        tick();

        // 4. start during busy ignored; start in the done cycle accepted
        accept8(8'd13, 8'd11, t0);
        tick();
        tick();
        bus8.start = 1'b1;
        bus8.a     = 8'd1;
        bus8.b     = 8'd1;
        tick();
        bus8.start = 1'b0;
        wait_done8("t13x11", t0, lat);
        chk("t13x11_lat", 64'(lat), 64'(lat8(8'd11)));
        chk("t13x11_prod", 64'(bus8.product), 64'd143);
        $display("op t13x11: 13 * 11 -> %0d in %0d cycles", bus8.product, lat);
        accept8(8'd2, 8'd3, t0);
        chk("b2b_done_low", 64'(bus8.done), 64'd0);
        chk("b2b_busy", 64'(bus8.busy), 64'd1);
        chk("b2b_prod_clr", 64'(bus8.product), 64'd0);
        wait_done8("t2x3", t0, lat);
        chk("t2x3_lat", 64'(lat), 64'(lat8(8'd3)));
        chk("t2x3_prod", 64'(bus8.product), 64'd6);
        $display("op t2x3: 2 * 3 -> %0d in %0d cycles", bus8.product, lat);
        tick();

        // 5. reset in the middle of 99*99 abandons it
        accept8(8'd99, 8'd99, t0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 64'(bus8.busy), 64'd0);
        chk("midrst_prod", 64'(bus8.product), 64'd0);
        bad_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus8.done) bad_done++;
            tick();
        end
        chk("midrst_no_done", 64'(bad_done), 64'd0);
        $display("op midrst: 99 * 99 abandoned, product %0d", bus8.product);
        run8("t5x7", 8'd5, 8'd7, 16'd35);
        tick();

        // 6. early-termination vectors (fixed latency 8 without the option)
        run8("t100x3", 8'd100, 8'd3, 16'd300);
        tick();
        run8("t100x0", 8'd100, 8'd0, 16'd0);
        tick();
        run8("t100x128", 8'd100, 8'd128, 16'd12800);
        tick();

        // WIDTH=32 random sweep against the golden product
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom();
            rb = $urandom();
            if (n == 0) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
            if (n == 1) rb = 32'd0;
            if (n == 2) rb = 32'd1;
            if (n == 3) rb = 32'h0000_8000;
            if (n >= 4 && (n % 4) == 0) rb = rb >> (n % 29);
            rexp = 64'(ra) * 64'(rb);
            bus32.start = 1'b1;
            bus32.a     = ra;
            bus32.b     = rb;
            tick();
            bus32.start = 1'b0;
            t0 = cyc;
            while (!bus32.done && (cyc - t0) < 70) tick();
            lat = cyc - t0;
            if (!bus32.done) chk("w32_timeout", 64'd0, 64'd1);
            chk("w32_lat", 64'(lat), 64'(lat32(rb)));
            chk("w32_prod", bus32.product, rexp);
            $display("op w32[%0d]: %0d * %0d -> %0d in %0d cycles", n, ra, rb, bus32.product, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
